// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI-Stream beat FIFO built from a synchronous-read RAM whose
// read register doubles as the output register. FRAME_MODE=0 passes beats
// through as soon as they are written; FRAME_MODE=1 holds beats back until
// their frame's tlast has been accepted, and discards frames that can never fit.
`timescale 1ns/1ps

module axis_pkt_fifo #(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 512,
  parameter int FRAME_MODE   = 0,
  parameter int AFULL_LEVEL  = DEPTH - 8,
  parameter int AEMPTY_LEVEL = 8
) (
  input  logic                       s_axis_aclk,
  input  logic                       s_axis_areset,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [$clog2(DEPTH):0]     status_count,
  output logic [$clog2(DEPTH):0]     status_frames,
  output logic                       status_afull,
  output logic                       status_aempty,
  output logic                       status_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] L_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] L_ONE   = PW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DROP} state_t;

  // Each RAM word carries the beat data plus its tlast flag in the top bit.
  logic [DATA_WIDTH:0]   r_mem [DEPTH];

  logic [PW-1:0]         r_wr_ptr, r_cm_ptr, r_rd_ptr;
  logic [PW-1:0]         r_count, r_frames;
  state_t                r_state, w_state_next;
  logic                  r_s_tready;
  logic                  r_m_tvalid, r_m_last_raw;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_afull, r_aempty, r_drop;

  logic                  w_accept, w_deliver, w_wr_en, w_rd_en;
  logic                  w_in_drop, w_drop_now, w_commit, w_frame_in;
  logic [PW-1:0]         w_avail_ptr, w_uncommitted;
  logic [PW-1:0]         w_count_next, w_frames_next;

  assign w_accept  = s_axis_tvalid && r_s_tready;
  assign w_deliver = r_m_tvalid && m_axis_tready;

  // Write state register (only leaves IDLE in store-and-forward mode).
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      r_state <= w_state_next;
    end
  end

  // Write state transitions: frame start, frame end, oversize drop.
  always_comb begin
    // NOTE: default first, so no path through this block can infer a latch.
    w_state_next = r_state;
    if (FRAME_MODE != 0) begin
      case (r_state)
        ST_IDLE:  if (w_accept && !s_axis_tlast) w_state_next = ST_WRITE;
        ST_WRITE: if (w_drop_now)                w_state_next = ST_DROP;
                  else if (w_accept && s_axis_tlast) w_state_next = ST_IDLE;
        ST_DROP:  if (w_accept && s_axis_tlast)  w_state_next = ST_IDLE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  // Write state outputs: discard mode, oversize detection, commit strobe.
  always_comb begin
    w_in_drop  = (FRAME_MODE != 0) && (r_state == ST_DROP);
    // Full of one unfinished frame with nothing committed: it can never fit.
    w_drop_now = (FRAME_MODE != 0) && (r_state == ST_WRITE) &&
                 (r_count == L_DEPTH) && (r_frames == '0);
    w_wr_en    = w_accept && !w_in_drop;
    w_frame_in = w_wr_en && s_axis_tlast;
    w_commit   = (FRAME_MODE != 0) && w_frame_in;
  end

  // Read side sees committed beats in store-and-forward, all beats otherwise.
  assign w_avail_ptr   = (FRAME_MODE != 0) ? r_cm_ptr : r_wr_ptr;
  assign w_uncommitted = r_wr_ptr - r_cm_ptr;
  // Refill the output register whenever it is empty or being emptied.
  assign w_rd_en = (r_rd_ptr != w_avail_ptr) && (!r_m_tvalid || m_axis_tready);

  assign w_count_next  = r_count - (w_drop_now ? w_uncommitted : '0)
                       + {{(PW-1){1'b0}}, w_wr_en}
                       - {{(PW-1){1'b0}}, w_deliver};
  assign w_frames_next = r_frames
                       + {{(PW-1){1'b0}}, w_frame_in}
                       - {{(PW-1){1'b0}}, w_deliver && r_m_last_raw};

  // RAM write port and synchronous read into the output data register.
  // NOTE: RAM and output data have no reset; contents are don't-care until
  // valid, and a reset would prevent mapping onto block RAM.
  always_ff @(posedge s_axis_aclk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    if (w_rd_en) begin
      r_m_tdata    <= r_mem[r_rd_ptr[AW-1:0]][DATA_WIDTH-1:0];
      r_m_last_raw <= r_mem[r_rd_ptr[AW-1:0]][DATA_WIDTH];
    end
  end

  // Pointers, output valid, occupancy and registered status flags.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      r_wr_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_frames   <= '0;
      r_s_tready <= 1'b0;
      r_m_tvalid <= 1'b0;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_drop     <= 1'b0;
    end else begin
      if (w_drop_now)   r_wr_ptr <= r_cm_ptr;
      else if (w_wr_en) r_wr_ptr <= r_wr_ptr + L_ONE;
      if (w_commit)     r_cm_ptr <= r_wr_ptr + L_ONE;
      if (w_rd_en)      r_rd_ptr <= r_rd_ptr + L_ONE;

      if (w_rd_en)            r_m_tvalid <= 1'b1;
      else if (m_axis_tready) r_m_tvalid <= 1'b0;

      r_count    <= w_count_next;
      r_frames   <= w_frames_next;
      r_s_tready <= (w_state_next == ST_DROP) || (w_count_next < L_DEPTH);
      r_afull    <= int'(w_count_next) >= AFULL_LEVEL;
      r_aempty   <= int'(w_count_next) <= AEMPTY_LEVEL;
      r_drop     <= w_drop_now;
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  // The raw tlast flop has no reset, so qualify it with the reset valid.
  assign m_axis_tlast  = r_m_last_raw && r_m_tvalid;
  assign status_count  = r_count;
  assign status_frames = r_frames;
  assign status_afull  = r_afull;
  assign status_aempty = r_aempty;
  assign status_drop   = r_drop;

endmodule
